// File: rtl/halflife_pkg.sv
// Shared definitions for the half-life decay controller: default widths,
// FSM state encoding and a small saturating-increment helper.
package halflife_pkg;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned PW_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4,
    ST_CLEAR = 3'd5
  } state_e;

  // Increment that sticks at all-ones; callers pass the width-limited value.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    return (val >= max) ? max : val + 32'd1;
  endfunction

endpackage

// File: rtl/halflife_prescaler.sv
// Cycle prescaler for the WAIT phase: counts enabled cycles and flags the
// cycle in which the count reaches period-1.
module halflife_prescaler
  import halflife_pkg::*;
#(
  parameter int unsigned PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [PW-1:0] period,
  output logic          expire
);

  logic [PW-1:0] cnt_q;

  // period is never 0 here; the controller maps 0 to 1 when latching it
  assign expire = enable && (cnt_q == (period - PW'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + PW'(1);
    end
  end

endmodule

// File: rtl/halflife_ctrl.sv
// Half-life decay controller: drives an external up/down counter so that its
// value halves once every `period` cycles until it reaches zero.
module halflife_ctrl
  import halflife_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned PW = PW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  init_val,
  input  logic [PW-1:0] period,
  input  logic [N-1:0]  count,
  output logic          load,
  output logic [N-1:0]  in,
  output logic          up,
  output logic          down,
  output logic          busy,
  output logic          half_pulse,
  output logic          done,
  output logic [N-1:0]  hl_count
);

  state_e        state_q, state_d;
  logic [PW-1:0] period_q;
  logic [N-1:0]  target_q;
  logic [N-1:0]  hl_q;
  logic          load_q, busy_q, done_q;
  logic [N-1:0]  in_q;

  logic          pre_clear, pre_en, pre_expire;
  logic          capture, hl_inc, down_d, half_d;
  logic          at_target;

  assign pre_en    = (state_q == ST_WAIT);
  assign pre_clear = !pre_en;
  assign at_target = (count == target_q);

  halflife_prescaler #(.PW(PW)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (pre_clear),
    .enable (pre_en),
    .period (period_q),
    .expire (pre_expire)
  );

  // Next-state and same-cycle strobes; abort overrides everything outside IDLE
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    hl_inc  = 1'b0;
    down_d  = 1'b0;
    half_d  = 1'b0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (count == '0) begin
          state_d = ST_DONE;
        end else if (pre_expire) begin
          capture = 1'b1;
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        if (!at_target) begin
          down_d = 1'b1;
        end else begin
          hl_inc = 1'b1;
          if (target_q == '0) begin
            state_d = ST_DONE;
          end else begin
            half_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_CLEAR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_CLEAR;
      capture = 1'b0;
      hl_inc  = 1'b0;
      down_d  = 1'b0;
      half_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      target_q <= '0;
      hl_q     <= '0;
      load_q   <= 1'b0;
      in_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == ST_IDLE) && start) begin
        period_q <= (period == '0) ? PW'(1) : period;
        hl_q     <= '0;
      end else if (hl_inc) begin
        hl_q <= N'(sat_inc(32'(hl_q), 32'({N{1'b1}})));
      end
      if (capture) target_q <= count >> 1;
      // LOAD is only entered from IDLE with start, so init_val is latched here
      load_q <= (state_d == ST_LOAD) || (state_d == ST_CLEAR);
      in_q   <= (state_d == ST_LOAD) ? init_val : '0;
      busy_q <= (state_d != ST_IDLE);
      done_q <= (state_d == ST_DONE);
    end
  end

  assign load       = load_q;
  assign in         = in_q;
  assign up         = 1'b0;
  assign down       = down_d;
  assign busy       = busy_q;
  assign half_pulse = half_d;
  assign done       = done_q;
  assign hl_count   = hl_q;

endmodule

// File: doc/halflife_ctrl.md
HALFLIFE_CTRL -- requirements
Module: halflife_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the width of the decay counter value.
REQ-002 The block SHALL have parameter PW, default 8, giving the width of the period register.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  begins a decay run when sampled high in IDLE.
REQ-006 The block SHALL have port abort  input  1  cancels a run and clears the downstream counter.
REQ-007 The block SHALL have port init_val  input  N  initial count, sampled with start.
REQ-008 The block SHALL have port period  input  PW  cycles per half-life, sampled with start.
REQ-009 The block SHALL have port count  input  N  registered value fed back from the up/down counter.
REQ-010 The block SHALL have port load  output  1  counter load strobe.
REQ-011 The block SHALL have port in  output  N  counter load value.
REQ-012 The block SHALL have port up  output  1  counter increment strobe; constant 0.
REQ-013 The block SHALL have port down  output  1  counter decrement strobe.
REQ-014 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 The block SHALL have port half_pulse  output  1  one-cycle pulse per completed non-final halving.
REQ-016 The block SHALL have port done  output  1  one-cycle pulse when the count reaches 0.
REQ-017 The block SHALL have port hl_count  output  N  halvings completed in the current run, saturating at 2^N-1.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, LOAD, WAIT, STEP, DONE and CLEAR.
REQ-019 In IDLE, start=1 SHALL latch init_val and period (period 0 treated as 1), clear hl_count and move to LOAD; start in any other state SHALL be ignored.
REQ-020 LOAD SHALL last one cycle with load=1 and in=latched init_val, then move to WAIT.
REQ-021 On WAIT entry the prescaler SHALL clear; it SHALL increment each WAIT cycle and, if count==0, WAIT SHALL go directly to DONE.
REQ-022 When the prescaler equals latched period-1, the block SHALL capture target=count>>1 (logical shift) and move to STEP, so WAIT lasts exactly period cycles.
REQ-023 In STEP, down SHALL be combinationally 1 exactly while count!=target, giving one decrement per cycle and no overshoot.
REQ-024 When count==target in STEP, hl_count SHALL increment (saturating); if target==0 the next state SHALL be DONE, else WAIT with half_pulse=1 in that cycle.
REQ-025 DONE SHALL last one cycle with done=1, then move to IDLE.
REQ-026 abort=1 in any non-IDLE state SHALL override all other transitions and move to CLEAR; abort in IDLE SHALL be ignored.
REQ-027 CLEAR SHALL last one cycle with load=1 and in=0, then move to IDLE.
REQ-028 load and down SHALL never be high in the same cycle, and up SHALL always be 0.
REQ-029 in SHALL be 0 whenever load=0.

Reset
REQ-030 With rst=1 at a clock edge, the block SHALL enter IDLE, clear the prescaler, target and hl_count, and hold load, down, busy, half_pulse and done at 0 from the next cycle, including mid-run.
REQ-031 rst SHALL take priority over abort and start.

Structure
REQ-032 A shared package halflife_pkg SHALL hold the state enum and the N and PW default constants.
REQ-033 The prescaler SHALL be a sub-module named halflife_prescaler with clear, enable, period and expire signals.

Verification
REQ-034 The bench SHALL check start with init_val=8 and period=4 -> count sequence 8,4,2,1,0, three half_pulse pulses, done once, hl_count=4, and 8 down strobes in total.
REQ-035 The bench SHALL check start with init_val=0 -> one load cycle, then done in the first WAIT cycle, with hl_count=0 and no down strobes.
REQ-036 The bench SHALL check start with init_val=15 and period=0 -> WAIT lasts 1 cycle per halving, and counts run 15,7,3,1,0.
REQ-037 The bench SHALL check abort asserted mid-STEP -> down drops that cycle, then one load with in=0, then IDLE with busy=0 and count=0.
REQ-038 The bench SHALL check rst asserted mid-WAIT -> all outputs 0 in the next cycle, and a start asserted during rst is ignored.
REQ-039 The bench SHALL check start held high while busy -> no restart and no second load.
